// File: rtl/dadder_dp_out_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dadder_dp_out_rx_pkg : shared types and helpers for the dadder DP receiver |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package dadder_dp_out_rx_pkg;

    // FIFO entries carry the widest supported magnitude, left-aligned.
    localparam int         MAX_DIGITS  = 8;
    localparam int         MAX_DIG_W   = 4 * MAX_DIGITS;
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [MAX_DIG_W-1:0] digits;
        logic                 sign;
        logic                 overflow;
    } fifo_entry_t;

    function automatic int bin_width(input int num_digits);
        longint p;
        p = 1;
        for (int i = 0; i < num_digits; i++) begin
            p = p * 10;
        end
        return $clog2(p);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dadder_dp_out_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dadder_dp_out_rx_fifo : synchronous FIFO, registered count/full/empty      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module dadder_dp_out_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             empty_q;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is dropped even when a pop happens alongside.
    assign w_do_push = push_i & ~full_q;
    assign w_do_pop  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_do_push && w_do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule
`default_nettype wire

// File: rtl/dadder_dp_out_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dadder_dp_out_rx : buffers dadder BCD results, converts to binary serially |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module dadder_dp_out_rx
    import dadder_dp_out_rx_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int BIN_W      = bin_width(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_digits,
    input  logic                    in_sign,
    input  logic                    in_overflow,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIN_W-1:0]        out_bin,
    output logic                    out_sign,
    output logic                    out_overflow,
    output logic                    out_err,
    output logic [7:0]              err_cnt
);

    localparam int               PAD      = 4 * (MAX_DIGITS - NUM_DIGITS);
    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam int               ENTRY_W  = $bits(fifo_entry_t);

    fifo_entry_t          w_wr_entry;
    fifo_entry_t          w_rd_entry;
    logic [ENTRY_W-1:0]   w_rd_data;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    state_e               state_q, state_d;
    logic [BIN_W-1:0]     acc_q, acc_d;
    logic [MAX_DIG_W-1:0] sr_q, sr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 err_q, err_d;
    logic                 sign_q, sign_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic                 ready_q;

    logic [3:0]           w_nib;
    logic                 w_nib_bad;
    logic [3:0]           w_digit;
    logic [BIN_W-1:0]     w_acc_x10;

    // Left-align the magnitude so the converter always reads the top nibble.
    always_comb begin
        w_wr_entry.digits   = MAX_DIG_W'(in_digits) << PAD;
        w_wr_entry.sign     = in_sign;
        w_wr_entry.overflow = in_overflow;
    end

    assign w_push     = in_valid & in_ready;
    assign w_rd_entry = w_rd_data;

    dadder_dp_out_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (w_push),
        .wr_data_i (w_wr_entry),
        .pop_i     (w_pop),
        .rd_data_o (w_rd_data),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty)
    );

    assign w_nib     = sr_q[MAX_DIG_W-1 -: 4];
    assign w_nib_bad = (w_nib > 4'd9);
    assign w_digit   = w_nib_bad ? 4'd0 : w_nib;
    assign w_acc_x10 = (acc_q << 3) + (acc_q << 1);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sr_d      = sr_q;
        idx_d     = idx_q;
        err_d     = err_q;
        sign_d    = sign_q;
        ovf_d     = ovf_q;
        err_cnt_d = err_cnt_q;
        w_pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_pop = ~w_fifo_empty;
            end
            ST_CONV: begin
                acc_d = w_acc_x10 + BIN_W'(w_digit);
                err_d = err_q | w_nib_bad;
                sr_d  = sr_q << 4;
                idx_d = idx_q - 1'b1;
                if (idx_q == '0) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (err_q && (err_cnt_q != ERR_CNT_MAX)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = ST_IDLE;
                    w_pop   = ~w_fifo_empty;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_pop) begin
            acc_d   = '0;
            err_d   = 1'b0;
            sr_d    = w_rd_entry.digits;
            sign_d  = w_rd_entry.sign;
            ovf_d   = w_rd_entry.overflow;
            idx_d   = IDX_LAST;
            state_d = ST_CONV;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            sr_q      <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sr_q      <= sr_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            sign_q    <= sign_d;
            ovf_q     <= ovf_d;
            err_cnt_q <= err_cnt_d;
            ready_q   <= 1'b1;
        end
    end

    // ready_q holds in_ready low through reset; full is the registered next-count full.
    assign in_ready     = ready_q & ~w_fifo_full;
    assign out_valid    = (state_q == ST_HOLD);
    assign out_bin      = acc_q;
    assign out_sign     = sign_q;
    assign out_overflow = ovf_q;
    assign out_err      = err_q;
    assign err_cnt      = err_cnt_q;

endmodule
`default_nettype wire
